systolic_mac_arbiter: RTL and testbench

SYSTOLIC_MAC_ARBITER -- requirements
Module: systolic_mac_arbiter

---
 rtl/systolic_mac_arbiter.sv | 165 ++++++++++++++++
 tb/tb_systolic_mac_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_arbiter.sv
// systolic_mac_arbiter
// Two requesters share one external registered multiplier. A burst from the
// granted requester is multiplied beat by beat and accumulated into a
// saturating dot-product. The result is returned with the owner id and a
// sticky overflow flag. Arbitration is round-robin when both requesters are
// valid in IDLE.
module systolic_mac_arbiter #(
    parameter int OPW  = 6,
    parameter int ACCW = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    input  logic                req1_valid,
    output logic                req0_ready,
    output logic                req1_ready,
    input  logic [OPW-1:0]      req0_a,
    input  logic [OPW-1:0]      req0_b,
    input  logic [OPW-1:0]      req1_a,
    input  logic [OPW-1:0]      req1_b,
    input  logic                req0_last,
    input  logic                req1_last,
    output logic [OPW-1:0]      mul_a,
    output logic [OPW-1:0]      mul_b,
    input  logic [2*OPW-1:0]    mul_c,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ACCW-1:0]     res_data,
    output logic                res_id,
    output logic                res_ovf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t            state_q;
    logic              grant_q;
    logic              rr_q;
    logic              pend_q;
    logic [ACCW-1:0]   acc_q;
    logic              ovf_q;
    logic              res_valid_q;
    logic [ACCW-1:0]   res_data_q;
    logic              res_id_q;
    logic              res_ovf_q;

    logic [ACCW-1:0]   acc_d;
    logic              ovf_d;
    logic [ACCW:0]     sum;

    // Requester-indexed views of the flat ports
    logic [1:0]        req_valid;
    logic [1:0]        req_last;
    logic [1:0]        req_ready;
    logic [OPW-1:0]    req_a [2];
    logic [OPW-1:0]    req_b [2];

    assign req_valid = {req1_valid, req0_valid};
    assign req_last  = {req1_last, req0_last};
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;

    // Only the locked owner of the burst ever sees ready
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = (state_q == BURST) && (grant_q == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    logic accept;
    logic accept_last;
    assign accept      = (state_q == BURST) && req_valid[grant_q];
    assign accept_last = accept && req_last[grant_q];

    // Multiplier operands are driven only by an accepted beat; otherwise zero
    assign mul_a = accept ? req_a[grant_q] : '0;
    assign mul_b = accept ? req_b[grant_q] : '0;

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_ovf   = res_ovf_q;

    // Saturating accumulate of the product returned one cycle after acceptance;
    // the accumulator is cleared when the result is handed off
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        sum   = {1'b0, acc_q} + {{(ACCW + 1 - 2*OPW){1'b0}}, mul_c};
        if (pend_q) begin
            if (sum[ACCW]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACCW-1:0];
            end
        end
        if ((state_q == RESULT) && res_ready) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

    // Arbitration / burst control FSM with registered result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            rr_q        <= 1'b0;
            pend_q      <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            pend_q <= accept;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        grant_q <= (&req_valid) ? rr_q : req_valid[1];
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (accept_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // acc_d already includes the final product here
                    state_q     <= RESULT;
                    res_valid_q <= 1'b1;
                    res_data_q  <= acc_d;
                    res_id_q    <= grant_q;
                    res_ovf_q   <= ovf_d;
                end
                RESULT: begin
                    if (res_ready) begin
                        state_q     <= IDLE;
                        rr_q        <= ~grant_q;
                        res_valid_q <= 1'b0;
                        res_data_q  <= '0;
                        res_id_q    <= 1'b0;
                        res_ovf_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_mac_arbiter.sv
// Directed bench for systolic_mac_arbiter with a registered multiplier model.
module tb_systolic_mac_arbiter;

    localparam int OPW  = 6;
    localparam int ACCW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [OPW-1:0]    req0_a, req0_b, req1_a, req1_b;
    logic              req0_last, req1_last;
    logic [OPW-1:0]    mul_a, mul_b;
    logic [2*OPW-1:0]  mul_c;
    logic              res_valid;
    logic              res_ready;
    logic [ACCW-1:0]   res_data;
    logic              res_id;
    logic              res_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    systolic_mac_arbiter #(.OPW(OPW), .ACCW(ACCW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_last  (req0_last),
        .req1_last  (req1_last),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_c      (mul_c),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ovf    (res_ovf)
    );

    always #5 clk = ~clk;

    // External registered multiplier
    always @(posedge clk) mul_c <= mul_a * mul_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Starts in an IDLE cycle with both single-beat requests already driven
    task automatic single_burst(input int id, input int a, input int b, input int exp);
        #1;
        chk("sb_idle_rdy0", req0_ready, 0);
        chk("sb_idle_rdy1", req1_ready, 0);
        tick();
        #1;
        chk("sb_grant_rdy0", req0_ready, (id == 0));
        chk("sb_grant_rdy1", req1_ready, (id == 1));
        chk("sb_mul_a", mul_a, a);
        chk("sb_mul_b", mul_b, b);
        tick();
        #1;
        chk("sb_drain_valid", res_valid, 0);
        tick();
        #1;
        chk("sb_res_valid", res_valid, 1);
        chk("sb_res_data", res_data, exp);
        chk("sb_res_id", res_id, id);
        chk("sb_res_ovf", res_ovf, 0);
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = 6'd5; req0_b = 6'd7; req0_last = 1'b0;
        req1_a = 6'd0; req1_b = 6'd0; req1_last = 1'b0;
        res_ready  = 1'b0;

        // Reset values while a requester is already valid
        #3;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_ovf", res_ovf, 0);
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        // Both valid, single-beat bursts: grants alternate starting at 0
        req0_valid = 1'b1; req0_a = 6'd5; req0_b = 6'd7; req0_last = 1'b1;
        req1_valid = 1'b1; req1_a = 6'd9; req1_b = 6'd6; req1_last = 1'b1;
        res_ready  = 1'b1;
        single_burst(0, 5, 7, 35);
        single_burst(1, 9, 6, 54);
        single_burst(0, 5, 7, 35);
        single_burst(1, 9, 6, 54);

        // Back-to-back 3-beat burst from requester 0, result held 5 extra cycles
        req1_valid = 1'b0;
        req0_a = 6'd2; req0_b = 6'd3; req0_last = 1'b0;
        res_ready = 1'b0;
        #1;
        chk("b3_idle_rdy0", req0_ready, 0);
        tick();
        #1;
        chk("b3_rdy0", req0_ready, 1);
        chk("b3_mul_a0", mul_a, 2);
        tick();
        req0_a = 6'd4; req0_b = 6'd5;
        #1;
        chk("b3_mul_a1", mul_a, 4);
        chk("b3_mul_b1", mul_b, 5);
        tick();
        req0_a = 6'd63; req0_b = 6'd63; req0_last = 1'b1;
        #1;
        chk("b3_mul_a2", mul_a, 63);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("b3_drain_valid", res_valid, 0);
        chk("b3_drain_rdy0", req0_ready, 0);
        tick();
        #1;
        chk("b3_res_valid", res_valid, 1);
        chk("b3_res_data", res_data, 3995);
        chk("b3_res_id", res_id, 0);
        chk("b3_res_ovf", res_ovf, 0);
        req0_valid = 1'b1; req0_a = 6'd5; req0_b = 6'd7; req0_last = 1'b1;
        req1_valid = 1'b1; req1_a = 6'd9; req1_b = 6'd6; req1_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, 3995);
            chk("hold_id", res_id, 0);
            chk("hold_rdy0", req0_ready, 0);
            chk("hold_rdy1", req1_ready, 0);
        end
        res_ready = 1'b1;
        tick();
        #1;
        chk("hs_idle_valid", res_valid, 0);
        chk("hs_idle_rdy0", req0_ready, 0);
        chk("hs_idle_rdy1", req1_ready, 0);
        #1;
        // rr now points at requester 1
        single_burst(1, 9, 6, 54);

        // Saturation: 20 beats of 63*63 from requester 1
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 6'd63; req1_b = 6'd63; req1_last = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            req1_last = (i == 19);
            #1;
            chk("sat_rdy1", req1_ready, 1);
            chk("sat_mul_a", mul_a, 63);
            tick();
        end
        req1_valid = 1'b0;
        #1;
        chk("sat_drain_rdy1", req1_ready, 0);
        tick();
        #1;
        chk("sat_res_valid", res_valid, 1);
        chk("sat_res_data", res_data, 65535);
        chk("sat_res_id", res_id, 1);
        chk("sat_res_ovf", res_ovf, 1);
        tick();

        // Burst with gap cycles: accumulator frozen while valid is low
        req0_valid = 1'b1; req0_a = 6'd2; req0_b = 6'd3; req0_last = 1'b0;
        tick();
        #1;
        chk("gap_b0_mul_a", mul_a, 2);
        chk("gap_b0_acc", dut.acc_q, 0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("gap_g0_mul_a", mul_a, 0);
        chk("gap_g0_rdy0", req0_ready, 1);
        tick();
        req0_valid = 1'b1; req0_a = 6'd4; req0_b = 6'd5;
        #1;
        chk("gap_b1_acc", dut.acc_q, 6);
        chk("gap_b1_mul_a", mul_a, 4);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("gap_g1_acc", dut.acc_q, 6);
        chk("gap_g1_mul_b", mul_b, 0);
        tick();
        #1;
        chk("gap_g2_acc", dut.acc_q, 26);
        tick();
        req0_valid = 1'b1; req0_a = 6'd63; req0_b = 6'd63; req0_last = 1'b1;
        #1;
        chk("gap_b2_acc", dut.acc_q, 26);
        tick();
        req0_valid = 1'b0;
        tick();
        #1;
        chk("gap_res_valid", res_valid, 1);
        chk("gap_res_data", res_data, 3995);
        chk("gap_res_id", res_id, 0);
        chk("gap_res_ovf", res_ovf, 0);
        tick();

        // Reset after two beats discards the partial sum
        req0_valid = 1'b1; req0_a = 6'd10; req0_b = 6'd10; req0_last = 1'b0;
        tick();
        tick();
        #1;
        chk("mid_b1_mul_a", mul_a, 10);
        tick();
        #1;
        chk("mid_b2_rdy0", req0_ready, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_rdy0", req0_ready, 0);
        chk("mid_rst_mul_a", mul_a, 0);
        chk("mid_rst_mul_b", mul_b, 0);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_data", res_data, 0);
        chk("mid_rst_acc", dut.acc_q, 0);
        tick();
        reset = 1'b0;
        req0_valid = 1'b1; req0_a = 6'd3; req0_b = 6'd4; req0_last = 1'b1;
        req1_valid = 1'b1; req1_a = 6'd9; req1_b = 6'd6; req1_last = 1'b1;
        // rr was 1 before reset; after reset requester 0 must win
        single_burst(0, 3, 4, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
